// File: rtl/bp_me_mmio_dram_splitter.sv
// bp_me_mmio_dram_splitter: steers memory commands to host MMIO or DRAM by address and
// returns responses upstream in command order using a route FIFO.
module bp_me_mmio_dram_splitter #(
  parameter int msg_width_p = 128,
  parameter int addr_width_p = 40,
  parameter logic [addr_width_p-1:0] dram_base_addr_p = 40'h00_8000_0000,
  parameter int max_outstanding_p = 4,
  localparam int ptr_w = $clog2(max_outstanding_p),
  localparam int cnt_w = ptr_w + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    fence_i,
  input  logic [msg_width_p-1:0]  mem_cmd_i,
  input  logic [addr_width_p-1:0] mem_cmd_addr_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_yumi_o,
  output logic [msg_width_p-1:0]  mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_ready_i,
  output logic [msg_width_p-1:0]  host_cmd_o,
  output logic                    host_cmd_v_o,
  input  logic                    host_cmd_yumi_i,
  input  logic [msg_width_p-1:0]  host_resp_i,
  input  logic                    host_resp_v_i,
  output logic                    host_resp_ready_o,
  output logic [msg_width_p-1:0]  dram_cmd_o,
  output logic                    dram_cmd_v_o,
  input  logic                    dram_cmd_yumi_i,
  input  logic [msg_width_p-1:0]  dram_resp_i,
  input  logic                    dram_resp_v_i,
  output logic                    dram_resp_ready_o,
  output logic [cnt_w-1:0]        outstanding_o,
  output logic                    idle_o
);
  logic w_is_host, w_full, w_empty, w_head_host, w_issue, w_push, w_pop;
  logic [max_outstanding_p-1:0] r_route;
  logic [ptr_w-1:0] r_wptr, r_rptr;
  logic [cnt_w-1:0] r_cnt, w_host_cnt;
  // reset_i gates every handshake output so targets see nothing while it is held
  always_comb begin
    w_is_host = mem_cmd_addr_i < dram_base_addr_p;
    w_full = r_cnt == cnt_w'(max_outstanding_p);
    w_empty = r_cnt == '0;
    w_head_host = r_route[r_rptr];
    w_issue = ~reset_i & mem_cmd_v_i & ~w_full & ~fence_i;
    host_cmd_v_o = w_issue & w_is_host;
    dram_cmd_v_o = w_issue & ~w_is_host;
    mem_cmd_yumi_o = (host_cmd_v_o & host_cmd_yumi_i) | (dram_cmd_v_o & dram_cmd_yumi_i);
    w_push = mem_cmd_yumi_o;
    mem_resp_v_o = ~reset_i & ~w_empty & (w_head_host ? host_resp_v_i : dram_resp_v_i);
    mem_resp_o = w_head_host ? host_resp_i : dram_resp_i;
    host_resp_ready_o = ~reset_i & ~w_empty & w_head_host & mem_resp_ready_i;
    dram_resp_ready_o = ~reset_i & ~w_empty & ~w_head_host & mem_resp_ready_i;
    w_pop = mem_resp_v_o & mem_resp_ready_i;
  end
  assign host_cmd_o = mem_cmd_i;
  assign dram_cmd_o = mem_cmd_i;
  assign outstanding_o = r_cnt;
  assign idle_o = w_empty;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_route <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_route[r_wptr] <= w_is_host;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + cnt_w'(w_push) - cnt_w'(w_pop);
    end
  end
  // host entries currently live in the FIFO, used to catch unsolicited responses
  always_comb begin
    w_host_cnt = '0;
    for (int i = 0; i < max_outstanding_p; i++)
      w_host_cnt = w_host_cnt + cnt_w'(({1'b0, ptr_w'(i) - r_rptr} < r_cnt) & r_route[i]);
  end
  a_host_unsolicited: assert property (@(posedge clk_i) disable iff (reset_i) host_resp_v_i |-> w_host_cnt != '0);
  a_dram_unsolicited: assert property (@(posedge clk_i) disable iff (reset_i) dram_resp_v_i |-> r_cnt != w_host_cnt);
  a_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i) w_pop |-> !w_empty);
  a_host_yumi: assert property (@(posedge clk_i) disable iff (reset_i) host_cmd_yumi_i |-> host_cmd_v_o);
  a_dram_yumi: assert property (@(posedge clk_i) disable iff (reset_i) dram_cmd_yumi_i |-> dram_cmd_v_o);
endmodule

// File: tb/tb_bp_me_mmio_dram_splitter.sv
// tb_bp_me_mmio_dram_splitter: directed and random stimulus checked every cycle against
// a queue-based model of per-target and upstream response order.
module tb_bp_me_mmio_dram_splitter;
  localparam int MW = 128, AW = 40, D = 4;
  localparam logic [AW-1:0] BASE = 40'h00_8000_0000;
  logic clk = 0, rst = 1, fence = 0, cmd_v = 0, resp_ready = 0;
  logic host_yumi = 0, dram_yumi = 0, host_resp_v = 0, dram_resp_v = 0;
  logic cmd_yumi, resp_v, host_cmd_v, dram_cmd_v, host_ready, dram_ready, idle;
  logic [MW-1:0] cmd = 0, host_resp = 0, dram_resp = 0, resp, host_cmd, dram_cmd;
  logic [AW-1:0] addr = 0;
  logic [2:0] outst;
  typedef struct { bit h; logic [MW-1:0] d; } ent_t;
  ent_t exp_q[$];
  logic [MW-1:0] host_q[$], dram_q[$];
  int checks = 0, errors = 0;

  bp_me_mmio_dram_splitter dut (
    .clk_i(clk), .reset_i(rst), .fence_i(fence),
    .mem_cmd_i(cmd), .mem_cmd_addr_i(addr), .mem_cmd_v_i(cmd_v), .mem_cmd_yumi_o(cmd_yumi),
    .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_ready_i(resp_ready),
    .host_cmd_o(host_cmd), .host_cmd_v_o(host_cmd_v), .host_cmd_yumi_i(host_yumi),
    .host_resp_i(host_resp), .host_resp_v_i(host_resp_v), .host_resp_ready_o(host_ready),
    .dram_cmd_o(dram_cmd), .dram_cmd_v_o(dram_cmd_v), .dram_cmd_yumi_i(dram_yumi),
    .dram_resp_i(dram_resp), .dram_resp_v_i(dram_resp_v), .dram_resp_ready_o(dram_ready),
    .outstanding_o(outst), .idle_o(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string n, logic [MW-1:0] a, logic [MW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // each target answers with its command XOR a per-target signature
  function automatic logic [MW-1:0] rf(logic [MW-1:0] c, bit h);
    return c ^ (h ? {4{32'hA5A5_0001}} : {4{32'h5A5A_0002}});
  endfunction

  function automatic bit exp_cv(bit h);
    return cmd_v && ((addr < BASE) == h) && exp_q.size() < D && !fence;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return BASE - 1;
      2: return BASE;
      3: return '1;
      4: return AW'($urandom_range(0, 32'h7FFF_FFFF));
      default: return BASE + AW'($urandom);
    endcase
  endfunction

  task automatic drive(bit cv, logic [AW-1:0] a, bit f, bit rr, bit yw, bit hw, bit dw);
    cmd_v = cv; addr = a; fence = f; resp_ready = rr;
    cmd = {$urandom, $urandom, $urandom, $urandom};
    host_yumi = yw && exp_cv(1);
    dram_yumi = yw && exp_cv(0);
    host_resp_v = hw && host_q.size() > 0;
    host_resp = host_q.size() > 0 ? rf(host_q[0], 1) : {$urandom, $urandom, $urandom, $urandom};
    dram_resp_v = dw && dram_q.size() > 0;
    dram_resp = dram_q.size() > 0 ? rf(dram_q[0], 0) : {$urandom, $urandom, $urandom, $urandom};
    #1;
  endtask

  task automatic step();
    bit eh, ed, ne, hh, erv;
    @(negedge clk);
    eh = exp_cv(1);
    ed = exp_cv(0);
    ne = exp_q.size() > 0;
    hh = ne && exp_q[0].h;
    erv = ne && (hh ? host_resp_v : dram_resp_v);
    chk("host_cmd_v", host_cmd_v, eh);
    chk("dram_cmd_v", dram_cmd_v, ed);
    chk("cmd_yumi", cmd_yumi, (eh && host_yumi) || (ed && dram_yumi));
    chk("host_cmd", host_cmd, cmd);
    chk("dram_cmd", dram_cmd, cmd);
    chk("resp_v", resp_v, erv);
    if (erv) chk("resp_data", resp, exp_q[0].d);
    chk("host_ready", host_ready, hh && resp_ready);
    chk("dram_ready", dram_ready, ne && !hh && resp_ready);
    chk("outstanding", outst, exp_q.size());
    chk("idle", idle, !ne);
    @(posedge clk);
    if (erv && resp_ready) begin
      if (hh) void'(host_q.pop_front());
      else void'(dram_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (eh && host_yumi) begin
      host_q.push_back(cmd);
      exp_q.push_back('{1'b1, rf(cmd, 1)});
    end
    if (ed && dram_yumi) begin
      dram_q.push_back(cmd);
      exp_q.push_back('{1'b0, rf(cmd, 0)});
    end
    #1;
  endtask

  task automatic cyc(bit cv, logic [AW-1:0] a, bit f, bit rr, bit yw, bit hw, bit dw);
    drive(cv, a, f, rr, yw, hw, dw);
    step();
  endtask

  task automatic drain(bit f);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++)
      cyc(f, BASE, f, 1, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    int issued;
    cmd_v = 1; addr = BASE; resp_ready = 1;
    #12;
    chk("rst_dram_v", dram_cmd_v, 0);
    chk("rst_host_v", host_cmd_v, 0);
    chk("rst_outst", outst, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", dram_ready, 0);
    @(negedge clk) rst = 0;
    @(posedge clk) #1;
    // single DRAM read, response three cycles after issue
    drive(1, 40'h80000040, 0, 1, 1, 0, 0);
    chk("t1_dram_v", dram_cmd_v, 1);
    chk("t1_host_v", host_cmd_v, 0);
    step();
    chk("t1_outst1", outst, 1);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("t1_resp_v", resp_v, 1);
    step();
    chk("t1_outst0", outst, 0);
    // host MMIO
    drive(1, 40'h0030_0000, 0, 1, 1, 0, 0);
    chk("t2_host_v", host_cmd_v, 1);
    chk("t2_dram_v", dram_cmd_v, 0);
    step();
    drive(0, 0, 0, 1, 0, 1, 0);
    chk("t2_resp_v", resp_v, 1);
    step();
    chk("t2_idle", idle, 1);
    // ordering: host answers first but waits behind DRAM
    cyc(1, 40'h80000000, 0, 1, 1, 0, 0);
    cyc(1, 40'h00100000, 0, 1, 1, 0, 0);
    chk("t3_outst2", outst, 2);
    repeat (2) begin
      drive(0, 0, 0, 1, 0, 1, 0);
      chk("t3_host_held", host_ready, 0);
      chk("t3_resp_v0", resp_v, 0);
      step();
    end
    drive(0, 0, 0, 1, 0, 1, 1);
    chk("t3_dram_ready", dram_ready, 1);
    chk("t3_host_ready0", host_ready, 0);
    step();
    drive(0, 0, 0, 1, 0, 1, 0);
    chk("t3_host_fwd", resp_v, 1);
    step();
    chk("t3_idle", idle, 1);
    // full, same-cycle pop does not unblock, then wrap through 12 commands
    repeat (4) cyc(1, BASE + AW'($urandom_range(0, 4095)), 0, 1, 1, 0, 0);
    chk("t4_outst4", outst, 4);
    drive(1, BASE + 8, 0, 0, 1, 0, 0);
    chk("t4_full_v", dram_cmd_v, 0);
    step();
    drive(1, BASE + 8, 0, 1, 1, 0, 1);
    chk("t4_pop_same", dram_cmd_v, 0);
    chk("t4_popping", resp_v, 1);
    step();
    chk("t4_outst3", outst, 3);
    drive(1, BASE + 8, 0, 1, 1, 0, 0);
    chk("t4_unblock", dram_cmd_v, 1);
    step();
    issued = 5;
    for (int i = 0; i < 200 && issued < 12; i++) begin
      drive(1, BASE + AW'($urandom_range(0, 4095)), 0, 1, 1, 0, 1'($urandom_range(0, 1)));
      if (dram_yumi) issued++;
      step();
    end
    chk("t4_issued", 32'(issued), 12);
    drain(0);
    // fence with backpressure
    cyc(1, BASE, 0, 1, 1, 0, 0);
    cyc(1, BASE + 64, 0, 1, 1, 0, 0);
    repeat (5) begin
      drive(1, BASE, 1, 0, 1, 0, 1);
      chk("t5_fence_v", dram_cmd_v, 0);
      chk("t5_outst2", outst, 2);
      step();
    end
    drain(1);
    drive(1, BASE, 1, 1, 1, 0, 0);
    chk("t5_still_fenced", dram_cmd_v, 0);
    step();
    // async reset with three in flight
    cyc(1, BASE, 0, 1, 1, 0, 0);
    cyc(1, 40'h10, 0, 1, 1, 0, 0);
    cyc(1, BASE + 4, 0, 1, 1, 0, 0);
    chk("t6_outst3", outst, 3);
    drive(1, BASE, 0, 1, 0, 1, 1);
    #2 rst = 1;
    #1;
    chk("t6_outst0", outst, 0);
    chk("t6_idle", idle, 1);
    chk("t6_dram_v", dram_cmd_v, 0);
    chk("t6_resp_v", resp_v, 0);
    chk("t6_hready", host_ready, 0);
    host_resp_v = 0; dram_resp_v = 0;
    exp_q.delete(); host_q.delete(); dram_q.delete();
    @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk) #1;
    drive(1, 40'h0000_1000, 0, 1, 1, 0, 0);
    chk("t6_host_route", host_cmd_v, 1);
    chk("t6_dram_route", dram_cmd_v, 0);
    step();
    chk("t6_outst1", outst, 1);
    drain(0);
    // random traffic
    repeat (600)
      cyc(1'($urandom_range(0, 1)), rnd_addr(), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_me_mmio_dram_splitter.md
Name: bp_me_mmio_dram_splitter

Overview:
- Sits between the memory-side output of the CCE-to-wormhole bidir link and two memory-side targets: the nonsynth host MMIO block and the DRAM model.
- Steers each memory command by address (below DRAM base → host, otherwise → DRAM).
- Tracks up to max_outstanding_p in-flight requests in a route FIFO, so responses go back upstream in command order.
- Replaces the single-outstanding inline arbitration used around test harnesses today.

Parameters:
- msg_width_p, 128, width of packed bp_cce_mem_msg_s, opaque to this block
- addr_width_p, 40, physical address width
- dram_base_addr_p, 40'h00_8000_0000, first DRAM address; address < base → host
- max_outstanding_p, 4, route FIFO depth (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- fence_i  in  1  when high, no new command accepted
- mem_cmd_i  in  msg_width_p  upstream command message
- mem_cmd_addr_i  in  addr_width_p  address field of mem_cmd_i (sliced by parent)
- mem_cmd_v_i  in  1  upstream command valid
- mem_cmd_yumi_o  out  1  command consumed this cycle
- mem_resp_o  out  msg_width_p  upstream response
- mem_resp_v_o  out  1  response valid
- mem_resp_ready_i  in  1  upstream ready
- host_cmd_o / dram_cmd_o  out  msg_width_p  pass-through of mem_cmd_i
- host_cmd_v_o / dram_cmd_v_o  out  1  target command valid
- host_cmd_yumi_i / dram_cmd_yumi_i  in  1  target consumed command
- host_resp_i / dram_resp_i  in  msg_width_p  target response
- host_resp_v_i / dram_resp_v_i  in  1  target response valid
- host_resp_ready_o / dram_resp_ready_o  out  1  target response accepted when high with valid
- outstanding_o  out  clog2(max_outstanding_p)+1  in-flight count
- idle_o  out  1  outstanding_o == 0

Behaviour:
- Reset (async, any cycle): FIFO empty, outstanding_o=0, idle_o=1. All *_v_o, *_yumi_o and *_ready_o are 0 while reset_i is high. Any in-flight transaction is discarded.
- Routing: is_host = (mem_cmd_addr_i < dram_base_addr_p), unsigned compare, combinational.
- Command issue:
  - host_cmd_v_o = mem_cmd_v_i & is_host & ~full & ~fence_i; dram_cmd_v_o is the same with ~is_host.
  - A target may assert yumi only when its valid is high.
  - mem_cmd_yumi_o = selected target's yumi.
  - On yumi: push is_host into the route FIFO, outstanding +1.
  - Zero-cycle path: no command registering.
- Full: outstanding == max_outstanding_p → no command valid asserted. A same-cycle response pop does not unblock the push; the push waits until the next cycle.
- Response path:
  - Only when the FIFO is non-empty; head selects the source.
  - mem_resp_v_o = head_host ? host_resp_v_i : dram_resp_v_i.
  - mem_resp_o muxed from the same source.
  - Head target's ready = mem_resp_ready_i; the other target's ready = 0, so its response is held, not dropped.
  - Pop and outstanding −1 on mem_resp_v_o & mem_resp_ready_i.
- Empty FIFO: both target readies are 0 and mem_resp_v_o = 0, even if a target asserts valid.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance; wrap-around is modulo depth.
- Fence: blocks new issue only. Outstanding responses still drain, and idle_o is asserted when drained.
- Assertions (nonsynth):
  - A target responds while no entry for it is outstanding → error.
  - Pop while empty → error.
  - Target yumi without valid → error.

Test Plan:
- Single DRAM read: addr 0x80000040, dram yumi in cycle 0, response 3 cycles later → mem_resp_v_o=1 with DRAM payload, outstanding_o 1→0, host valid never asserted.
- Host MMIO: addr 0x0030_0000 → only host_cmd_v_o=1; host response is returned upstream and idle_o=1 afterwards.
- Ordering: issue DRAM 0x80000000 then host 0x00100000; host responds first → host_resp_ready_o=0 and held until the DRAM response pops, then the host response is forwarded. Upstream order is DRAM, host.
- Full + wrap: depth 4, issue 4 DRAM commands with no responses → 5th command sees dram_cmd_v_o=0. Pop one, 5th issues the next cycle. Run 12 commands total → all responses return in order.
- Fence and backpressure: fence_i=1 with 2 outstanding and mem_resp_ready_i=0 for 5 cycles → no issue, no pop, count stays 2. Release ready → drains, idle_o=1, fence still blocks the pending command.
- Async reset mid-flight: assert reset_i with 3 outstanding, between clock edges → outputs 0 immediately, outstanding_o=0. A new command after deassertion routes correctly.
